button_led_ctrl: RTL and testbench

Parametrised front-panel controller for the board's push-buttons and user LEDs: N active-low button inputs are synchronised, debounced and edge-detected, and each channel drives one LED in a per-channel selectable mode (direct, toggle, blink, off). It sits between the raw board pins and the SoC I/O fabric. It also exports clean pressed-levels and one-cycle press pulses to the processor side.

---
 rtl/button_led_ctrl.sv | 99 +++++++++
 tb/tb_button_led_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_led_ctrl.sv
// Front-panel button/LED controller: sync, debounce, edge detect, per-channel LED modes.
// Optional sticky press status and interrupt when LED_BTN_IRQ_EN is defined.
module button_led_ctrl #(
  parameter int N_CH       = 4,
  parameter int DEB_CYCLES = 16'd50000,
  parameter int BLINK_W    = 24
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [N_CH-1:0]     btn_n,
  input  logic [2*N_CH-1:0]   mode,
  output logic [N_CH-1:0]     pressed,
  output logic [N_CH-1:0]     press_pulse,
  output logic [N_CH-1:0]     led
`ifdef LED_BTN_IRQ_EN
  ,
  input  logic [N_CH-1:0]     irq_clr,
  output logic [N_CH-1:0]     btn_status,
  output logic                irq
`endif
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_TOGGLE = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;

  logic [N_CH-1:0]    sync_meta;
  logic [N_CH-1:0]    sync;
  logic [CW-1:0]      cnt     [N_CH];
  logic [CW-1:0]      cnt_nxt [N_CH];
  logic [N_CH-1:0]    accept;
  logic [N_CH-1:0]    tog;
  logic [N_CH-1:0]    led_nxt;
  logic [BLINK_W-1:0] div;

  always_comb begin
    cnt_nxt = cnt;
    accept  = '0;
    led_nxt = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (sync[i] == pressed[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        accept[i]  = 1'b1;
        cnt_nxt[i] = '0;
      end else if (cnt[i] != CNT_SAT) begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end

      // Toggle mode shows the value tog takes on this same edge.
      case (mode[2*i +: 2])
        MODE_DIRECT: led_nxt[i] = pressed[i];
        MODE_TOGGLE: led_nxt[i] = tog[i] ^ press_pulse[i];
        MODE_BLINK:  led_nxt[i] = div[BLINK_W-1];
        default:     led_nxt[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_meta   <= '0;
      sync        <= '0;
      cnt         <= '{default: '0};
      pressed     <= '0;
      press_pulse <= '0;
      tog         <= '0;
      div         <= '0;
      led         <= '0;
    end else begin
      sync_meta   <= ~btn_n;
      sync        <= sync_meta;
      cnt         <= cnt_nxt;
      pressed     <= pressed ^ accept;
      press_pulse <= accept & sync;
      tog         <= tog ^ press_pulse;
      div         <= div + BLINK_W'(1);
      led         <= led_nxt;
    end
  end

`ifdef LED_BTN_IRQ_EN
  // A press arriving together with a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      btn_status <= '0;
      irq        <= 1'b0;
    end else begin
      btn_status <= (btn_status & ~irq_clr) | press_pulse;
      irq        <= |btn_status;
    end
  end
`endif

endmodule

// File: tb/tb_button_led_ctrl.sv
// Bench for button_led_ctrl: directed test-plan checks plus random stimulus against a
// window-based reference model feeding a per-cycle scoreboard.
module tb_button_led_ctrl;
  localparam int N_CH = 4;
  localparam int DEB  = 8;
  localparam int BW   = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [N_CH-1:0]   btn_n;
  logic [2*N_CH-1:0] mode;
  logic [N_CH-1:0]   irq_clr;
  logic [N_CH-1:0]   pressed, press_pulse, led;
`ifdef LED_BTN_IRQ_EN
  logic [N_CH-1:0]   btn_status;
  logic              irq;
`endif

  always #5 clk = ~clk;

  button_led_ctrl #(.N_CH(N_CH), .DEB_CYCLES(DEB), .BLINK_W(BW)) dut (
    .clk(clk),
    .resetn(resetn),
    .btn_n(btn_n),
    .mode(mode),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .led(led)
`ifdef LED_BTN_IRQ_EN
    ,
    .irq_clr(irq_clr),
    .btn_status(btn_status),
    .irq(irq)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [N_CH-1:0] pressed;
    logic [N_CH-1:0] pulse;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] status;
    logic            irq;
  } exp_t;
  exp_t q[$];

  // Reference model: a level is accepted once the last DEB synchronised samples all
  // disagree with it and no reset/accept happened within that window.
  int              e = 0;
  int              last_clear[N_CH];
  logic [N_CH-1:0] hist[$];
  logic [N_CH-1:0] m_s1, m_sync, m_pressed, m_pulse, m_tog, m_led, m_status, acc, led_n, new_pulse;
  logic            m_irq;
  int unsigned     m_div;
  logic [1:0]      md;
  bit              ok;

  initial begin
    for (int i = 0; i < N_CH; i++) last_clear[i] = 0;
    forever begin
      @(posedge clk);
      e++;
      if (!resetn) begin
        m_s1 = '0; m_sync = '0; m_pressed = '0; m_pulse = '0; m_tog = '0;
        m_led = '0; m_status = '0; m_irq = 1'b0; m_div = 0;
        hist.delete();
        for (int i = 0; i < N_CH; i++) last_clear[i] = e;
      end else begin
        acc = '0;
        for (int i = 0; i < N_CH; i++) begin
          if (e - last_clear[i] >= DEB && hist.size() >= DEB) begin
            ok = 1'b1;
            for (int j = 0; j < DEB; j++)
              if (hist[hist.size()-1-j][i] == m_pressed[i]) ok = 1'b0;
            acc[i] = ok;
          end
        end
        for (int i = 0; i < N_CH; i++) begin
          md = mode[2*i +: 2];
          if (md == 2'd0)      led_n[i] = m_pressed[i];
          else if (md == 2'd1) led_n[i] = m_tog[i] ^ m_pulse[i];
          else if (md == 2'd2) led_n[i] = ((m_div >> (BW-1)) & 1) != 0;
          else                 led_n[i] = 1'b0;
        end
        m_irq     = |m_status;
        m_status  = (m_status & ~irq_clr) | m_pulse;
        m_tog     = m_tog ^ m_pulse;
        m_led     = led_n;
        new_pulse = acc & ~m_pressed;
        m_pressed = m_pressed ^ acc;
        for (int i = 0; i < N_CH; i++) if (acc[i]) last_clear[i] = e;
        m_pulse   = new_pulse;
        m_sync    = m_s1;
        m_s1      = ~btn_n;
        hist.push_back(m_sync);
        if (hist.size() > DEB) void'(hist.pop_front());
        m_div     = (m_div + 1) % (1 << BW);
      end
      q.push_back('{pressed: m_pressed, pulse: m_pulse, led: m_led, status: m_status, irq: m_irq});
    end
  end

  exp_t x;
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("sb_pressed", 32'(pressed), 32'(x.pressed));
        chk("sb_pulse", 32'(press_pulse), 32'(x.pulse));
        chk("sb_led", 32'(led), 32'(x.led));
`ifdef LED_BTN_IRQ_EN
        chk("sb_status", 32'(btn_status), 32'(x.status));
        chk("sb_irq", 32'(irq), 32'(x.irq));
`endif
      end
    end
  end

  int pc[N_CH];
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N_CH; i++) if (press_pulse[i] === 1'b1) pc[i]++;
    end
  endtask

  int base, hi, lo, n;
  int hold[N_CH];

  initial begin
    for (int i = 0; i < N_CH; i++) begin pc[i] = 0; hold[i] = 1; end
    resetn = 1'b0; btn_n = '1; mode = '0; irq_clr = '0;
    step(3);
    chk("rst_pressed", 32'(pressed), 0);
    chk("rst_pulse", 32'(press_pulse), 0);
    chk("rst_led", 32'(led), 0);
`ifdef LED_BTN_IRQ_EN
    chk("rst_status", 32'(btn_status), 0);
    chk("rst_irq", 32'(irq), 0);
`endif
    resetn = 1'b1;
    step(100);
    chk("idle_pressed", 32'(pressed), 0);
    chk("idle_led", 32'(led), 0);

    // clean press on channel 1
    btn_n[1] = 1'b0;
    step(9);
    chk("press_e9", 32'(pressed), 0);
    step(1);
    chk("press_e10", 32'(pressed), 32'h2);
    chk("pulse_e10", 32'(press_pulse), 32'h2);
    chk("led_e10", 32'(led), 0);
    step(1);
    chk("pulse_e11", 32'(press_pulse), 0);
    chk("led_e11", 32'(led), 32'h2);
    base = pc[1];
    btn_n[1] = 1'b1;
    step(9);
    chk("rel_e9", 32'(pressed), 32'h2);
    step(1);
    chk("rel_e10", 32'(pressed), 0);
    step(1);
    chk("rel_led_e11", 32'(led), 0);
    chk("rel_no_pulse", 32'(pc[1] - base), 0);

    // bounce rejection on channel 0
    base = pc[0];
    btn_n[0] = 1'b0; step(5);
    btn_n[0] = 1'b1; step(1);
    btn_n[0] = 1'b0;
    step(9);
    chk("bounce_e9", 32'(pressed[0]), 0);
    step(1);
    chk("bounce_e10", 32'(pressed[0]), 1);
    step(20);
    chk("bounce_one_pulse", 32'(pc[0] - base), 1);
    btn_n[0] = 1'b1;
    step(12);

    // toggle and mode switching on channel 2
    mode[5:4] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      btn_n[2] = 1'b0; step(12);
      btn_n[2] = 1'b1; step(12);
      chk("toggle_led", 32'(led[2]), (k == 1) ? 0 : 1);
    end
    mode[5:4] = 2'b11; step(1);
    chk("mode_off", 32'(led[2]), 0);
    mode[5:4] = 2'b01; step(1);
    chk("mode_retain", 32'(led[2]), 1);
    mode[5:4] = 2'b10;
    n = 0;
    while (led[2] !== 1'b0 && n < 40) begin step(1); n++; end
    while (led[2] !== 1'b1 && n < 40) begin step(1); n++; end
    hi = 0; lo = 0;
    while (led[2] === 1'b1 && hi < 40) begin step(1); hi++; end
    while (led[2] === 1'b0 && lo < 40) begin step(1); lo++; end
    chk("blink_high", 32'(hi), 8);
    chk("blink_period", 32'(hi + lo), 16);
    mode[5:4] = 2'b00;

`ifdef LED_BTN_IRQ_EN
    irq_clr = '1; step(1); irq_clr = '0; step(1);
    chk("irq_cleared_status", 32'(btn_status), 0);
    chk("irq_cleared_irq", 32'(irq), 0);
    btn_n[3] = 1'b0;
    step(11);
    chk("irq_status_set", 32'(btn_status), 32'h8);
    chk("irq_not_yet", 32'(irq), 0);
    step(1);
    chk("irq_raised", 32'(irq), 1);
    btn_n[3] = 1'b1; step(12);
    btn_n[3] = 1'b0; step(10);
    chk("irq_new_pulse", 32'(press_pulse[3]), 1);
    irq_clr = 4'b1000; step(1); irq_clr = '0;
    chk("irq_set_wins", 32'(btn_status), 32'h8);
    btn_n[3] = 1'b1; step(12);
    irq_clr = 4'b1000; step(1); irq_clr = '0;
    chk("irq_clr_status", 32'(btn_status), 0);
    chk("irq_still_high", 32'(irq), 1);
    step(1);
    chk("irq_dropped", 32'(irq), 0);
`endif

    // reset in the middle of a debounce with tog[0] = 1
    mode[1:0] = 2'b01; step(1);
    chk("pre_reset_tog", 32'(led[0]), 1);
    btn_n[0] = 1'b0;
    step(8);
    resetn = 1'b0; step(1);
    chk("midrst_pressed", 32'(pressed), 0);
    chk("midrst_led", 32'(led), 0);
    chk("midrst_pulse", 32'(press_pulse), 0);
    resetn = 1'b1;
    step(9);
    chk("midrst_e9", 32'(pressed[0]), 0);
    step(1);
    chk("midrst_e10", 32'(pressed[0]), 1);
    btn_n[0] = 1'b1;
    step(12);

    // random phase, checked by the scoreboard
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N_CH; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          btn_n[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 20);
        end
      end
      if ($urandom_range(0, 49) == 0) mode = (2*N_CH)'($urandom);
      irq_clr = ($urandom_range(0, 7) == 0) ? N_CH'($urandom) : '0;
      resetn = ($urandom_range(0, 399) != 0);
      step(1);
    end
    resetn = 1'b1; irq_clr = '0;
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
